// File: rtl/ysyx_25050141_pkg.sv
// Shared types and defaults for the instruction-memory responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_25050141_pkg;

   localparam int ysyx_25050141_INSTR_WIDTH = 32;
   localparam int ysyx_25050141_PC_WIDTH    = 32;

   // Legal fetch window: [MEM_BASE_DEF, MEM_BASE_DEF + MEM_SIZE_DEF)
   localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;
   localparam logic [31:0] MEM_SIZE_DEF = 32'h0800_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_e;

endpackage

// File: rtl/ysyx_25050141_imem_resp_if.sv
// Fetch request/response bundle between the fetch stage (master) and the imem responder (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both request and response channels.
interface ysyx_25050141_imem_resp_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/ysyx_25050141_Reg.sv
// Generic enable register with synchronous active-high reset.
// Latency: 1 cycle from din to dout when wen is high.
// Backpressure: none; holds value while wen is low.
// Ports: clk, rst, din/dout (WIDTH bits), wen.
module ysyx_25050141_Reg #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   input  logic             wen
);
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= RESET_VAL;
      end else if (wen) begin
         dout <= din;
      end
   end
endmodule

// File: rtl/ysyx_25050141_lat_cnt.sv
// 4-bit loadable down-counter that flags the last wait cycle of a fetch.
// Latency: load takes effect next cycle; done is combinational on the count.
// Backpressure: none; counts only while dec is high.
// Ports: clk, rst, load/load_val (start value), dec (count down), done (count==1).
module ysyx_25050141_lat_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       done
);
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Load wins over decrement: a fresh accept always restarts the count.
   assign cnt_d = load ? load_val : (cnt_q - 4'd1);

   ysyx_25050141_Reg #(.WIDTH(4), .RESET_VAL(4'd0)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .din  (cnt_d),
      .dout (cnt_q),
      .wen  (load | dec)
   );

   // count==1 is the last WAIT cycle; the FSM moves to RESP on this edge.
   assign done = (cnt_q == 4'd1);
endmodule

// File: rtl/ysyx_25050141_imem_resp.sv
// Instruction-memory responder: one fetch at a time, word returned after LATENCY cycles.
// Latency: rsp_valid rises LATENCY (1..15) cycles after the accept cycle.
// Backpressure: single outstanding request; RESP holds outputs frozen until rsp_ready.
// Ports: clk, rst (sync, active high); bus (slave side of the fetch interface);
//        mem_rd_en/mem_rd_addr/mem_rd_data: combinational backing-store lookup,
//        pulsed exactly once per legal accepted fetch, in the accept cycle.
module ysyx_25050141_imem_resp
   import ysyx_25050141_pkg::*;
#(
   parameter int                LATENCY  = 1,
   parameter int                ADDR_W   = ysyx_25050141_PC_WIDTH,
   parameter int                DATA_W   = ysyx_25050141_INSTR_WIDTH,
   parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(MEM_BASE_DEF),
   parameter logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(MEM_SIZE_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   ysyx_25050141_imem_resp_if.slave bus,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_rd_addr,
   input  logic [DATA_W-1:0]   mem_rd_data
);
   // One extra bit so BASE+SIZE cannot wrap at the top of the address space.
   localparam logic [ADDR_W:0] ADDR_LIMIT = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

   imem_state_e       state_q;
   imem_state_e       state_d;
   logic [1:0]        state_raw;
   logic              accept;
   logic              addr_err;
   logic              cnt_done;
   logic [DATA_W-1:0] data_q;
   logic              err_q;

   assign accept   = bus.req_valid & bus.req_ready;
   assign addr_err = (|bus.req_addr[1:0])
                   | (bus.req_addr < MEM_BASE)
                   | ({1'b0, bus.req_addr} >= ADDR_LIMIT);

   // Backing store is only touched for legal fetches, never for faulting ones.
   assign mem_rd_en   = accept & ~addr_err;
   assign mem_rd_addr = bus.req_addr;

   ysyx_25050141_Reg #(.WIDTH(2), .RESET_VAL(IDLE)) u_state (
      .clk  (clk),
      .rst  (rst),
      .din  (state_d),
      .dout (state_raw),
      .wen  (1'b1)
   );
   assign state_q = imem_state_e'(state_raw);

   // Word is captured at accept; only loaded again on the next accept,
   // so it holds across the handshake until a new fetch replaces it.
   ysyx_25050141_Reg #(.WIDTH(DATA_W), .RESET_VAL('0)) u_data (
      .clk  (clk),
      .rst  (rst),
      .din  (addr_err ? '0 : mem_rd_data),
      .dout (data_q),
      .wen  (accept)
   );

   ysyx_25050141_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_err (
      .clk  (clk),
      .rst  (rst),
      .din  (addr_err),
      .dout (err_q),
      .wen  (accept)
   );

   ysyx_25050141_lat_cnt u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (4'(LATENCY - 1)),
      .dec      (state_q == WAIT),
      .done     (cnt_done)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept)        state_d = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (cnt_done)      state_d = RESP;
         RESP: if (bus.rsp_ready) state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   assign bus.req_ready = (state_q == IDLE) & ~rst;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = data_q;
   assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_ysyx_25050141_imem_resp.sv
// Bench for the imem responder: four instances (LATENCY 1..4) share one stimulus stream.
// Latency: n/a.
// Backpressure: rsp_ready driven by directed tables, hand sequences and random stimulus.
module tb_ysyx_25050141_imem_resp;

   localparam int N = 4;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        rsp_ready;

   logic [N-1:0] ready_o;
   logic [N-1:0] valid_o;
   logic [N-1:0] err_o;
   logic [31:0]  data_o  [N];
   logic [N-1:0] rd_en;
   logic [31:0]  rd_addr [N];
   logic [31:0]  rd_data [N];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing store contents, derived purely from the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
   endfunction

   function automatic bit addr_bad(input logic [31:0] a);
      longint unsigned la;
      la = longint'(a);
      return (la % 4 != 0) || (la < 64'h8000_0000) || (la >= 64'h8000_0000 + 64'h0800_0000);
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      ysyx_25050141_imem_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();
      assign bus.req_valid = req_valid;
      assign bus.req_addr  = req_addr;
      assign bus.rsp_ready = rsp_ready;
      assign ready_o[g]    = bus.req_ready;
      assign valid_o[g]    = bus.rsp_valid;
      assign err_o[g]      = bus.rsp_err;
      assign data_o[g]     = bus.rsp_data;
      assign rd_data[g]    = mem_word(rd_addr[g]);

      ysyx_25050141_imem_resp #(.LATENCY(g + 1)) dut (
         .clk         (clk),
         .rst         (rst),
         .bus         (bus),
         .mem_rd_en   (rd_en[g]),
         .mem_rd_addr (rd_addr[g]),
         .mem_rd_data (rd_data[g])
      );
   end

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk32(nm, {31'd0, act}, {31'd0, exp});
   endtask

   // ---------------- reference model (time-based, per instance) ----------------
   int          cyc = 0;
   bit          chk_en = 0;
   bit          busy     [N];
   int          acc      [N];
   logic [31:0] hold_d   [N];
   bit          hold_e   [N];
   int          exp_calls[N];
   int          calls    [N];

   initial begin
      for (int i = 0; i < N; i++) begin
         busy[i] = 0; acc[i] = 0; hold_d[i] = '0; hold_e[i] = 0;
         exp_calls[i] = 0; calls[i] = 0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rd_en[i]) calls[i]++;
         if (rst) begin
            busy[i] = 0; hold_d[i] = '0; hold_e[i] = 0;
         end else if (!busy[i]) begin
            if (req_valid) begin
               busy[i]   = 1;
               acc[i]    = cyc;
               hold_e[i] = addr_bad(req_addr);
               hold_d[i] = hold_e[i] ? 32'd0 : mem_word(req_addr);
               if (!hold_e[i]) exp_calls[i]++;
            end
         end else if (cyc >= acc[i] + i + 1 && rsp_ready) begin
            busy[i] = 0;
         end
      end
      cyc++;
      chk_en = 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < N; i++) begin
            bit ev;
            ev = busy[i] && (cyc >= acc[i] + i + 1);
            chk1($sformatf("L%0d req_ready", i + 1), ready_o[i], !rst && !busy[i]);
            chk1($sformatf("L%0d rsp_valid", i + 1), valid_o[i], ev);
            if (ev) begin
               chk32($sformatf("L%0d rsp_data", i + 1), data_o[i], hold_d[i]);
               chk1($sformatf("L%0d rsp_err", i + 1), err_o[i], hold_e[i]);
            end else if (!busy[i]) begin
               chk32($sformatf("L%0d held rsp_data", i + 1), data_o[i], hold_d[i]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      bit          v;
      logic [31:0] a;
      bit          r;
      bit          e_rdy;
      bit          e_vld;
      bit          e_err;
      logic [31:0] e_dat;
   } vec_t;

   function automatic vec_t mk(bit v, logic [31:0] a, bit r, bit er, bit ev, bit ee, logic [31:0] ed);
      vec_t t;
      t.v = v; t.a = a; t.r = r; t.e_rdy = er; t.e_vld = ev; t.e_err = ee; t.e_dat = ed;
      return t;
   endfunction

   task automatic drive(input bit r, input bit v, input logic [31:0] a, input bit k);
      @(posedge clk);
      #1;
      rst = r; req_valid = v; req_addr = a; rsp_ready = k;
   endtask

   vec_t tbl[26];

   initial begin
      int c0, c1, seen, n, last_acc, n_acc;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;

      // Reset behaviour.
      @(negedge clk);
      chk1("rst req_ready", ready_o[0], 1'b0);
      chk1("rst rsp_valid", valid_o[0], 1'b0);
      chk32("rst rsp_data", data_o[0], 32'd0);
      @(negedge clk);
      chk1("rst req_ready 2", ready_o[0], 1'b0);
      drive(0, 0, 32'd0, 0);
      @(negedge clk);
      chk1("post-rst req_ready", ready_o[0], 1'b1);

      // Directed table, viewed through the LATENCY=3 instance.
      tbl[0]  = mk(1, 32'h8000_0000, 1, 1, 0, 0, 32'd0);
      tbl[1]  = mk(0, 32'h0,         1, 0, 0, 0, 32'd0);
      tbl[2]  = mk(0, 32'h0,         0, 0, 0, 0, 32'd0);
      tbl[3]  = mk(1, 32'h8000_0004, 0, 0, 1, 0, 32'h0000_0413);
      tbl[4]  = mk(1, 32'h8000_0004, 0, 0, 1, 0, 32'h0000_0413);
      tbl[5]  = mk(1, 32'h8000_0004, 0, 0, 1, 0, 32'h0000_0413);
      tbl[6]  = mk(1, 32'h8000_0004, 0, 0, 1, 0, 32'h0000_0413);
      tbl[7]  = mk(1, 32'h8000_0004, 0, 0, 1, 0, 32'h0000_0413);
      tbl[8]  = mk(0, 32'h0,         1, 0, 1, 0, 32'h0000_0413);
      tbl[9]  = mk(1, 32'h8000_0002, 1, 1, 0, 0, 32'd0);
      tbl[10] = mk(0, 32'h0,         1, 0, 0, 0, 32'd0);
      tbl[11] = mk(0, 32'h0,         1, 0, 0, 0, 32'd0);
      tbl[12] = mk(0, 32'h0,         1, 0, 1, 1, 32'd0);
      tbl[13] = mk(1, 32'h7FFF_FFFC, 1, 1, 0, 0, 32'd0);
      tbl[14] = mk(0, 32'h0,         1, 0, 0, 0, 32'd0);
      tbl[15] = mk(0, 32'h0,         1, 0, 0, 0, 32'd0);
      tbl[16] = mk(0, 32'h0,         1, 0, 1, 1, 32'd0);
      tbl[17] = mk(1, 32'h87FF_FFFC, 1, 1, 0, 0, 32'd0);
      tbl[18] = mk(0, 32'h0,         1, 0, 0, 0, 32'd0);
      tbl[19] = mk(0, 32'h0,         1, 0, 0, 0, 32'd0);
      tbl[20] = mk(0, 32'h0,         1, 0, 1, 0, mem_word(32'h87FF_FFFC));
      tbl[21] = mk(1, 32'h8800_0000, 1, 1, 0, 0, 32'd0);
      tbl[22] = mk(0, 32'h0,         1, 0, 0, 0, 32'd0);
      tbl[23] = mk(0, 32'h0,         1, 0, 0, 0, 32'd0);
      tbl[24] = mk(0, 32'h0,         1, 0, 1, 1, 32'd0);
      tbl[25] = mk(0, 32'h0,         1, 1, 0, 0, 32'd0);

      c0 = calls[2];
      for (int k = 0; k < 26; k++) begin
         drive(0, tbl[k].v, tbl[k].a, tbl[k].r);
         @(negedge clk);
         chk1($sformatf("tbl[%0d] req_ready", k), ready_o[2], tbl[k].e_rdy);
         chk1($sformatf("tbl[%0d] rsp_valid", k), valid_o[2], tbl[k].e_vld);
         if (tbl[k].e_vld) begin
            chk32($sformatf("tbl[%0d] rsp_data", k), data_o[2], tbl[k].e_dat);
            chk1($sformatf("tbl[%0d] rsp_err", k), err_o[2], tbl[k].e_err);
         end
      end
      chk32("tbl L3 fetch calls", 32'(calls[2] - c0), 32'd2);

      // Reset during WAIT drops the transaction (LATENCY=4).
      repeat (6) drive(0, 0, 32'd0, 1);
      drive(0, 1, 32'h8000_0010, 1);
      @(negedge clk);
      chk1("midrst accept", ready_o[3], 1'b1);
      drive(0, 0, 32'd0, 1);
      drive(1, 0, 32'd0, 1);
      seen = 0;
      repeat (8) begin
         drive(0, 0, 32'd0, 1);
         @(negedge clk);
         if (valid_o[3]) seen = 1;
      end
      chk32("midrst no response", 32'(seen), 32'd0);
      drive(0, 1, 32'h8000_0020, 1);
      n = 0;
      do begin
         drive(0, 0, 32'd0, 1);
         n++;
         @(negedge clk);
      end while (!valid_o[3] && n < 20);
      chk32("midrst next latency", 32'(n), 32'd4);
      chk32("midrst next data", data_o[3], mem_word(32'h8000_0020));

      // Back-to-back with req_valid held high (LATENCY=2).
      repeat (6) drive(0, 0, 32'd0, 1);
      c1 = calls[1];
      last_acc = -1; n_acc = 0;
      for (int k = 0; k < 15; k++) begin
         drive(0, 1, 32'h8000_0100 + 32'(4 * k), 1);
         @(negedge clk);
         if (ready_o[1]) begin
            if (last_acc >= 0) chk32("b2b spacing", 32'(k - last_acc), 32'd3);
            last_acc = k;
            n_acc++;
         end
      end
      drive(0, 0, 32'd0, 1);
      chk32("b2b accepts", 32'(n_acc), 32'd5);
      chk32("b2b fetch calls", 32'(calls[1] - c1), 32'd5);

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         logic [31:0] a;
         int sel;
         sel = $urandom_range(0, 9);
         case (sel)
            0: a = 32'h8000_0000 + {18'd0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
            1: a = $urandom_range(0, 32'h7FFF_FFFF) & 32'hFFFF_FFFC;
            2: a = 32'h87FF_FFFC;
            3: a = 32'h8800_0000;
            4: a = 32'h7FFF_FFFC;
            default: a = 32'h8000_0000 + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
         endcase
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0);
      end
      repeat (8) drive(0, 0, 32'd0, 1);
      @(negedge clk);
      for (int i = 0; i < N; i++)
         chk32($sformatf("L%0d total fetch calls", i + 1), 32'(calls[i]), 32'(exp_calls[i]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
